// File: rtl/sddac_mod2_mch.sv
// Multichannel second-order sigma-delta modulator, one shared adder, time-serial.
// Define SDDAC_MOD2_DITHER_EN to add an LFSR dither term at the quantizer.
module sddac_mod2_mch #(
    parameter int NCH = 2,
    parameter int DW  = 18,
    parameter int IW  = 24,
    parameter int FS  = 65536,
    parameter int DIV = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*DW-1:0] sample_in,
    input  logic              sample_in_rdy,
    input  logic              sat_clr,
    output logic [NCH-1:0]    dout,
    output logic              frame_strb,
    output logic              sat_flag
);

    localparam int PW = $clog2(DIV);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = IW + 2;

    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PH_OUT  = PW'(2 * NCH - 1);

    localparam logic signed [SW-1:0] FS_W   = SW'(FS);
    localparam logic signed [SW-1:0] MAX_W  = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_W  = {3'b111, {(IW-1){1'b0}}};
    localparam logic signed [SW-1:0] ZERO_W = '0;

    typedef enum logic [1:0] {
        ACT_A,
        ACT_B,
        IDLE
    } st_t;

    st_t                st, st_nxt;
    logic [PW-1:0]      ph, ph_nxt;
    logic [CW-1:0]      ch;

    logic [NCH*DW-1:0]  hold, work, x_src;
    logic signed [IW-1:0] i1 [NCH];
    logic signed [IW-1:0] i2 [NCH];
    logic [NCH-1:0]     q, q_nxt;

    logic signed [IW-1:0] i1_s, i2_s, res;
    logic [DW-1:0]      x_s;
    logic               fb_bit;
    logic signed [SW-1:0] op_a, op_b, v, sum, qsum;
    logic               clamp_hi, clamp_lo, sat_ev, q_bit;
    logic [8:0]         dith;

    // Frame phase drives the whole schedule; the enum just names the slot type.
    always_comb begin
        ph_nxt = (ph == PH_LAST) ? '0 : ph + 1'b1;
        st_nxt = IDLE;
        if (ph_nxt <= PH_OUT) begin
            st_nxt = ph_nxt[0] ? ACT_B : ACT_A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph <= '0;
            st <= ACT_A;
        end else begin
            ph <= ph_nxt;
            st <= st_nxt;
        end
    end

    assign ch    = CW'(ph >> 1);
    assign x_src = (ph == '0) ? hold : work;

    always_comb begin
        i1_s   = '0;
        i2_s   = '0;
        x_s    = '0;
        fb_bit = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (ch == CW'(k)) begin
                i1_s   = i1[k];
                i2_s   = i2[k];
                x_s    = x_src[k*DW +: DW];
                fb_bit = dout[k];
            end
        end
    end

`ifdef SDDAC_MOD2_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (ph == '0) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign dith = {1'b0, lfsr[7:0]} - 9'd128;
`else
    assign dith = '0;
`endif

    // Shared adder: ACT_A integrates the input, ACT_B integrates I1.
    always_comb begin
        v        = fb_bit ? FS_W : -FS_W;
        op_a     = (st == ACT_A) ? {{2{i1_s[IW-1]}}, i1_s}
                                 : {{2{i2_s[IW-1]}}, i2_s};
        op_b     = (st == ACT_A) ? {{(SW-DW){x_s[DW-1]}}, x_s}
                                 : {{2{i1_s[IW-1]}}, i1_s};
        sum      = op_a + op_b - v;
        clamp_hi = sum > MAX_W;
        clamp_lo = sum < MIN_W;
        if (clamp_hi) begin
            res = MAX_W[IW-1:0];
        end else if (clamp_lo) begin
            res = MIN_W[IW-1:0];
        end else begin
            res = sum[IW-1:0];
        end
        sat_ev = (st != IDLE) && (clamp_hi || clamp_lo);
        qsum   = {{2{res[IW-1]}}, res} + {{(SW-9){dith[8]}}, dith};
        q_bit  = qsum >= ZERO_W;
    end

    always_comb begin
        q_nxt = q;
        if (st == ACT_B) begin
            for (int k = 0; k < NCH; k++) begin
                if (ch == CW'(k)) begin
                    q_nxt[k] = q_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= '0;
            work <= '0;
        end else begin
            if (sample_in_rdy) begin
                hold <= sample_in;
            end
            if (ph == '0) begin
                work <= hold;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                i1[k] <= '0;
                i2[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (ch == CW'(k) && st == ACT_A) begin
                    i1[k] <= res;
                end
                if (ch == CW'(k) && st == ACT_B) begin
                    i2[k] <= res;
                end
            end
        end
    end

    // The last channel's bit is forwarded so all outputs switch together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= '0;
            dout       <= '0;
            frame_strb <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            q          <= q_nxt;
            frame_strb <= (ph == PH_OUT);
            if (ph == PH_OUT) begin
                dout <= q_nxt;
            end
            if (sat_ev) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sddac_mod2_mch.sv
// Scoreboard bench for sddac_mod2_mch: frame-level reference model vs DUT.
// Model computes each frame with plain integer arithmetic and clamps.
module tb_sddac_mod2_mch;

    localparam int NCH = 2;
    localparam int DW  = 18;
    localparam int IW  = 24;
    localparam int FS  = 65536;
    localparam int DIV = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*DW-1:0] sample_in = '0;
    logic              sample_in_rdy = 1'b0;
    logic              sat_clr = 1'b0;
    logic [NCH-1:0]    dout;
    logic              frame_strb;
    logic              sat_flag;

    always #5 clk = ~clk;

    sddac_mod2_mch #(
        .NCH(NCH), .DW(DW), .IW(IW), .FS(FS), .DIV(DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_in_rdy(sample_in_rdy),
        .sat_clr      (sat_clr),
        .dout         (dout),
        .frame_strb   (frame_strb),
        .sat_flag     (sat_flag)
    );

    typedef struct {
        logic [NCH-1:0] dout;
        logic           sat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int fcnt = 0;
    int first_strb_cyc = -1;
    int ones[NCH];
    logic [2:0] first3 = '0;
    logic prev_strb = 1'b0;

    longint            m_i1[NCH];
    longint            m_i2[NCH];
    bit [NCH-1:0]      m_dout;
    bit                m_sat;
    logic [NCH*DW-1:0] m_hold;
    logic [15:0]       m_lfsr;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int val,
                             input int lo, input int hi);
        nvec++;
        if (val < lo || val > hi) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic longint clampv(longint s);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (IW - 1)) - 1;
        lo = -(longint'(1) <<< (IW - 1));
        if (s > hi) begin
            m_sat = 1'b1;
            return hi;
        end
        if (s < lo) begin
            m_sat = 1'b1;
            return lo;
        end
        return s;
    endfunction

    // One whole modulation frame for every channel.
    task automatic model_frame();
        longint x;
        longint v;
        longint d;
        bit [NCH-1:0] qv;
        d = 0;
`ifdef SDDAC_MOD2_DITHER_EN
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
        d = longint'(m_lfsr[7:0]) - 128;
`endif
        for (int k = 0; k < NCH; k++) begin
            x = longint'($signed(m_hold[k*DW +: DW]));
            v = m_dout[k] ? longint'(FS) : -longint'(FS);
            m_i1[k] = clampv(m_i1[k] + x - v);
            m_i2[k] = clampv(m_i2[k] + m_i1[k] - v);
            qv[k] = (m_i2[k] + d) >= 0;
        end
        m_dout = qv;
        sb.push_back('{qv, m_sat});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            fcnt = 0;
            first_strb_cyc = -1;
            prev_strb = 1'b0;
            for (int k = 0; k < NCH; k++) ones[k] = 0;
        end else begin
            if (frame_strb) begin
                check("strb_width", {63'd0, prev_strb}, 64'd0);
                if (sb.size() == 0) begin
                    check("unexpected_frame", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("dout", {62'd0, dout}, {62'd0, mon_e.dout});
                    check("sat_flag", {63'd0, sat_flag}, {63'd0, mon_e.sat});
                end
                if (fcnt == 0) first_strb_cyc = cyc;
                if (fcnt < 3) first3[fcnt] = dout[0];
                for (int k = 0; k < NCH; k++) ones[k] += int'(dout[k]);
                fcnt++;
            end
            prev_strb = frame_strb;
        end
    end

    task automatic step(input bit stb, input logic [NCH*DW-1:0] val,
                        input bit clr);
        logic [63:0] r;
        if (cyc % DIV == 0) model_frame();
        r = {$urandom, $urandom};
        sample_in = stb ? val : r[NCH*DW-1:0];
        sample_in_rdy = stb;
        sat_clr = clr;
        if (stb) m_hold = val;
        if (clr) m_sat = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sample_in_rdy = 1'b0;
        sat_clr = 1'b0;
        if (clr) check("sat_clr", {63'd0, sat_flag}, 64'd0);
    endtask

    // mode 0: one strobe per frame at a random phase
    // mode 1: random values strobed at phases 0, 2 and 5
    // mode 2: like mode 0 plus occasional sat_clr in the idle slot
    task automatic run_frames(input int n, input int mode,
                              input logic [DW-1:0] x0,
                              input logic [DW-1:0] x1);
        int sp;
        bit clr_f;
        logic [63:0] r;
        for (int f = 0; f < n; f++) begin
            sp = $urandom_range(0, DIV - 1);
            clr_f = (mode == 2) && ($urandom_range(0, 7) == 0);
            for (int p = 0; p < DIV; p++) begin
                r = {$urandom, $urandom};
                if (mode == 1) begin
                    step(p == 0 || p == 2 || p == 5, r[NCH*DW-1:0], 1'b0);
                end else begin
                    step(p == sp, {x1, x0}, clr_f && p == 5);
                end
            end
        end
    endtask

    task automatic reset_dut(input int n);
        reset = 1'b1;
        #1;
        check("rst_dout", {62'd0, dout}, 64'd0);
        check("rst_strb", {63'd0, frame_strb}, 64'd0);
        check("rst_sat", {63'd0, sat_flag}, 64'd0);
        for (int k = 0; k < NCH; k++) begin
            m_i1[k] = 0;
            m_i2[k] = 0;
        end
        m_dout = '0;
        m_sat = 1'b0;
        m_hold = '0;
        m_lfsr = 16'hACE1;
        sb.delete();
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_dout_hold", {62'd0, dout}, 64'd0);
        check("rst_strb_hold", {63'd0, frame_strb}, 64'd0);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        reset_dut(2);
        run_frames(2, 0, '0, '0);
        // Park at ph = 3 and reset mid-frame.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        reset_dut(3);

        run_frames(256, 0, '0, '0);
        check("drain_zero", 64'(sb.size()), 64'd0);
        check("first_strb_cyc", 64'(first_strb_cyc), 64'd4);
`ifdef SDDAC_MOD2_DITHER_EN
        check_rng("zero_ones0", ones[0], 120, 136);
        check_rng("zero_ones1", ones[1], 120, 136);
`else
        check("first3_dout0", {61'd0, first3}, 64'd3);
        check_rng("zero_ones0", ones[0], 126, 130);
        check_rng("zero_ones1", ones[1], 126, 130);
`endif

        reset_dut(2);
        run_frames(256, 0, 18'sd32768, -18'sd32768);
        check("drain_dc", 64'(sb.size()), 64'd0);
`ifdef SDDAC_MOD2_DITHER_EN
        check_rng("dc_ones0", ones[0], 184, 200);
        check_rng("dc_ones1", ones[1], 56, 72);
`else
        check_rng("dc_ones0", ones[0], 190, 194);
        check_rng("dc_ones1", ones[1], 62, 66);
`endif
        check("dc_sat", {63'd0, sat_flag}, 64'd0);

        reset_dut(2);
        run_frames(64, 1, '0, '0);
        check("drain_hs", 64'(sb.size()), 64'd0);

        reset_dut(2);
        run_frames(32, 0, 18'sd131071, 18'($urandom));
        check("sat_rise", {63'd0, sat_flag}, 64'd1);
        run_frames(224, 2, 18'sd131071, 18'($urandom));
        check("drain_sat", 64'(sb.size()), 64'd0);

        reset_dut(2);
        for (int i = 0; i < 8; i++) begin
            run_frames(16, 2, 18'($urandom), 18'($urandom));
        end
        check("drain_rand", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
